// File: rtl/fll_cfg_clkgen_if.sv
// Config-bus bundle for fll_cfg_clkgen: level request held until a one-cycle
// acknowledge, 3-bit register address, 32-bit write and read data.
interface fll_cfg_clkgen_if;
  logic        cfg_req;
  logic        cfg_wrn;
  logic [2:0]  cfg_add;
  logic [31:0] cfg_data;
  logic        cfg_ack;
  logic [31:0] cfg_r_data;

  modport master (
    output cfg_req, cfg_wrn, cfg_add, cfg_data,
    input  cfg_ack, cfg_r_data
  );

  modport slave (
    input  cfg_req, cfg_wrn, cfg_add, cfg_data,
    output cfg_ack, cfg_r_data
  );
endinterface

// File: rtl/fll_cfg_clkgen.sv
// Multi-channel integer clock divider with a config-bus register map.
// Each channel produces a 50% duty divided clock, a per-period enable and a lock flag.
module fll_cfg_clkgen #(
  parameter int N_CH     = 2,
  parameter int DIV_W    = 8,
  parameter int LOCK_CYC = 16,
  parameter int DIV_RST  = 1,
  parameter int EN_RST   = 1
) (
  input  logic             ref_clk_i,
  input  logic             rst_i,
  fll_cfg_clkgen_if.slave  cfg,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  clk_en_o,
  output logic [N_CH-1:0]  lock_o
);

  localparam int               LCK_W    = $clog2(LOCK_CYC + 1);
  localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_CYC);
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);
  localparam logic             EN_INIT  = (EN_RST != 0);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [N_CH-1:0]  ctrl_en;
  logic [DIV_W-1:0] ctrl_div [N_CH];
  logic [DIV_W-1:0] d_act    [N_CH];
  logic [DIV_W-1:0] cnt      [N_CH];
  logic [LCK_W-1:0] lock_cnt [N_CH];
  logic [N_CH-1:0]  clk_q;

  logic [N_CH-1:0]  wr_sel;
  logic [N_CH-1:0]  wr_chg;
  logic [DIV_W-1:0] new_div;
  logic             new_en;
  logic [31:0]      rd_word;
  logic [31:0]      r_data;
  logic             unused_data;

  function automatic logic [LCK_W-1:0] sat_inc(input logic [LCK_W-1:0] v);
    return (v == LOCK_MAX) ? v : v + 1'b1;
  endfunction

  assign new_div     = cfg.cfg_data[8 +: DIV_W];
  assign new_en      = cfg.cfg_data[0];
  assign unused_data = ^{cfg.cfg_data[31:8+DIV_W], cfg.cfg_data[7:1]};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg.cfg_req) begin
          accept    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:      state_nxt = WAIT_LOW;
      WAIT_LOW: if (!cfg.cfg_req) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Decode per channel; addresses with ch >= N_CH match no channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i]   = accept && cfg.cfg_wrn && !cfg.cfg_add[0] && (cfg.cfg_add[2:1] == 2'(i));
      wr_chg[i]   = wr_sel[i] && ((new_div != ctrl_div[i]) || (new_en != ctrl_en[i]));
      clk_en_o[i] = ctrl_en[i] && (cnt[i] == d_act[i]);
      lock_o[i]   = (lock_cnt[i] == LOCK_MAX);
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg.cfg_add[2:1] == 2'(i)) begin
        if (cfg.cfg_add[0]) begin
          rd_word[0]          = lock_o[i];
          rd_word[1]          = ctrl_en[i];
          rd_word[8 +: DIV_W] = d_act[i];
        end else begin
          rd_word[0]          = ctrl_en[i];
          rd_word[8 +: DIV_W] = ctrl_div[i];
        end
      end
    end
  end

  // Read data is captured at accept and cleared again after the ack cycle.
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      r_data <= '0;
    end else begin
      state  <= state_nxt;
      r_data <= (accept && !cfg.cfg_wrn) ? rd_word : '0;
    end
  end

  assign cfg.cfg_ack    = (state == ACK);
  assign cfg.cfg_r_data = r_data;

  // While disabled, d_act tracks the divider about to be in CTRL so that an
  // enable write starts counting with its own div value. When running, d_act
  // only reloads at the terminal count, so a period is never cut short.
  always_ff @(posedge ref_clk_i) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst_i) begin
        ctrl_en[i]  <= EN_INIT;
        ctrl_div[i] <= DIV_INIT;
        d_act[i]    <= DIV_INIT;
        cnt[i]      <= '0;
        clk_q[i]    <= 1'b0;
        lock_cnt[i] <= '0;
      end else begin
        if (wr_sel[i]) begin
          ctrl_en[i]  <= new_en;
          ctrl_div[i] <= new_div;
        end
        if (!ctrl_en[i]) begin
          cnt[i]   <= '0;
          clk_q[i] <= 1'b0;
          d_act[i] <= wr_sel[i] ? new_div : ctrl_div[i];
        end else if (cnt[i] == d_act[i]) begin
          cnt[i]   <= '0;
          clk_q[i] <= ~clk_q[i];
          d_act[i] <= ctrl_div[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (wr_chg[i] || !ctrl_en[i]) lock_cnt[i] <= '0;
        else                          lock_cnt[i] <= sat_inc(lock_cnt[i]);
      end
    end
  end

  assign clk_o = clk_q;

endmodule
